// File: rtl/mips_fwd_pipe_cpu.sv
// mips_fwd_pipe_cpu
//   Single-clock 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset pipeline with operand
//   forwarding, load-use interlock, taken-branch flush and HLT drain.
//   Mem[] (unified, word addressed) and Reg[] are internal and are not reset.
// Ports
//   clk1          sole clock, all state on posedge
//   rst_n         asynchronous active-low reset (pipeline, PC, status only)
//   halted        HLT has retired from WB; core frozen until reset
//   retire_pulse  1 while a valid (non-bubble) instruction occupies WB
//   stall_count   saturating count of cycles IF/ID was held by an interlock
module mips_fwd_pipe_cpu #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned FORWARD_EN = 1
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic        halted,
  output logic        retire_pulse,
  output logic [15:0] stall_count
);
  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam int unsigned MEM_W = (DATA_W > 32) ? DATA_W : 32;

  typedef enum logic [5:0] {
    OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3, OP_SLT = 6'd4,
    OP_MUL = 6'd5, OP_LW = 6'd8, OP_SW = 6'd9, OP_ADDI = 6'd10, OP_SUBI = 6'd11,
    OP_SLTI = 6'd12, OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_HLT = 6'd63
  } opcode_e;

  logic [MEM_W-1:0]  Mem [MEM_DEPTH];
  logic [DATA_W-1:0] Reg [32];

  logic [AW-1:0]     r_pc;
  logic              r_fetch_frozen, r_halted;
  logic [15:0]       r_stall_cnt;
  // IF/ID
  logic              r_ifid_v;
  logic [31:0]       r_ifid_ir;
  logic [AW-1:0]     r_ifid_pc;
  // ID/EX
  logic              r_idex_v, r_idex_we;
  logic [5:0]        r_idex_op;
  logic [4:0]        r_idex_rs, r_idex_rt, r_idex_dst;
  logic [DATA_W-1:0] r_idex_a, r_idex_b, r_idex_imm;
  logic [AW-1:0]     r_idex_pc;
  // EX/MEM
  logic              r_exmem_v, r_exmem_we, r_exmem_lw, r_exmem_sw, r_exmem_hlt;
  logic [4:0]        r_exmem_dst;
  logic [DATA_W-1:0] r_exmem_res, r_exmem_sd;
  // MEM/WB
  logic              r_memwb_v, r_memwb_we, r_memwb_hlt;
  logic [4:0]        r_memwb_dst;
  logic [DATA_W-1:0] r_memwb_res;

  // ---------------- ID: decode, register read with WB bypass ----------------
  logic [5:0]        w_op;
  logic [4:0]        w_rs, w_rt, w_rd, w_dst;
  logic [DATA_W-1:0] w_imm, w_id_a, w_id_b;
  logic              w_is_rr, w_is_imm, w_is_lw, w_is_sw, w_is_br;
  logic              w_use_rs, w_use_rt, w_we, w_id_hlt;

  assign w_op  = r_ifid_ir[31:26];
  assign w_rs  = r_ifid_ir[25:21];
  assign w_rt  = r_ifid_ir[20:16];
  assign w_rd  = r_ifid_ir[15:11];
  assign w_imm = DATA_W'($signed(r_ifid_ir[15:0]));

  always_comb begin
    w_is_rr  = w_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
    w_is_imm = w_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
    w_is_lw  = (w_op == OP_LW);
    w_is_sw  = (w_op == OP_SW);
    w_is_br  = w_op inside {OP_BNEQZ, OP_BEQZ};
    w_use_rs = r_ifid_v && (w_is_rr || w_is_imm || w_is_lw || w_is_sw || w_is_br);
    w_use_rt = r_ifid_v && (w_is_rr || w_is_sw);
    w_dst    = w_is_rr ? w_rd : w_rt;
    // R0 destinations are dropped here so no later stage treats them as producers.
    w_we     = r_ifid_v && (w_is_rr || w_is_imm || w_is_lw) && (w_dst != 5'd0);
    w_id_hlt = r_ifid_v && (w_op == OP_HLT);

    if (w_rs == 5'd0)                              w_id_a = '0;
    else if (r_memwb_we && (r_memwb_dst == w_rs)) w_id_a = r_memwb_res;
    else                                           w_id_a = Reg[w_rs];
    if (w_rt == 5'd0)                              w_id_b = '0;
    else if (r_memwb_we && (r_memwb_dst == w_rt)) w_id_b = r_memwb_res;
    else                                           w_id_b = Reg[w_rt];
  end

  // ---------------- EX: forwarding, ALU, branch resolve ----------------
  logic [DATA_W-1:0] w_fa, w_fb, w_alu;
  logic              w_taken;
  logic [AW-1:0]     w_target;

  always_comb begin
    w_fa = r_idex_a;
    w_fb = r_idex_b;
    if (FORWARD_EN != 0) begin
      // EX/MEM checked first: it is the younger producer.
      if (r_exmem_we && (r_exmem_dst == r_idex_rs))      w_fa = r_exmem_res;
      else if (r_memwb_we && (r_memwb_dst == r_idex_rs)) w_fa = r_memwb_res;
      if (r_exmem_we && (r_exmem_dst == r_idex_rt))      w_fb = r_exmem_res;
      else if (r_memwb_we && (r_memwb_dst == r_idex_rt)) w_fb = r_memwb_res;
    end
    case (r_idex_op)
      OP_ADD:         w_alu = w_fa + w_fb;
      OP_SUB:         w_alu = w_fa - w_fb;
      OP_AND:         w_alu = w_fa & w_fb;
      OP_OR:          w_alu = w_fa | w_fb;
      OP_SLT:         w_alu = DATA_W'($signed(w_fa) < $signed(w_fb));
      OP_MUL:         w_alu = w_fa * w_fb;
      OP_LW, OP_SW,
      OP_ADDI:        w_alu = w_fa + r_idex_imm;
      OP_SUBI:        w_alu = w_fa - r_idex_imm;
      OP_SLTI:        w_alu = DATA_W'($signed(w_fa) < $signed(r_idex_imm));
      default:        w_alu = '0;
    endcase
    w_taken  = r_idex_v && (((r_idex_op == OP_BEQZ)  && (w_fa == '0)) ||
                            ((r_idex_op == OP_BNEQZ) && (w_fa != '0)));
    w_target = r_idex_pc + AW'(1) + r_idex_imm[AW-1:0];
  end

  // ---------------- Hazard detection ----------------
  logic w_match_ex, w_match_mem, w_hazard, w_stall, w_freeze;

  always_comb begin
    w_match_ex  = r_idex_we && ((w_use_rs && (r_idex_dst == w_rs)) ||
                                (w_use_rt && (r_idex_dst == w_rt)));
    w_match_mem = r_exmem_we && ((w_use_rs && (r_exmem_dst == w_rs)) ||
                                 (w_use_rt && (r_exmem_dst == w_rt)));
    if (FORWARD_EN != 0) w_hazard = w_match_ex && (r_idex_op == OP_LW);
    else                 w_hazard = w_match_ex || w_match_mem;
    // A taken branch flushes the waiting consumer, so it overrides the stall.
    w_stall  = w_hazard && !w_taken;
    w_freeze = w_id_hlt || r_fetch_frozen;
  end

  // ---------------- MEM ----------------
  logic [AW-1:0]     w_mem_addr;
  logic [DATA_W-1:0] w_mem_res;
  assign w_mem_addr = r_exmem_res[AW-1:0];
  assign w_mem_res  = r_exmem_lw ? Mem[w_mem_addr][DATA_W-1:0] : r_exmem_res;

  // ---------------- Pipeline state ----------------
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;  r_fetch_frozen <= 1'b0;  r_halted <= 1'b0;  r_stall_cnt <= '0;
      r_ifid_v <= 1'b0;  r_ifid_ir <= '0;  r_ifid_pc <= '0;
      r_idex_v <= 1'b0;  r_idex_we <= 1'b0;  r_idex_op <= '0;  r_idex_rs <= '0;
      r_idex_rt <= '0;  r_idex_dst <= '0;  r_idex_a <= '0;  r_idex_b <= '0;
      r_idex_imm <= '0;  r_idex_pc <= '0;
      r_exmem_v <= 1'b0;  r_exmem_we <= 1'b0;  r_exmem_lw <= 1'b0;  r_exmem_sw <= 1'b0;
      r_exmem_hlt <= 1'b0;  r_exmem_dst <= '0;  r_exmem_res <= '0;  r_exmem_sd <= '0;
      r_memwb_v <= 1'b0;  r_memwb_we <= 1'b0;  r_memwb_hlt <= 1'b0;
      r_memwb_dst <= '0;  r_memwb_res <= '0;
    end else begin
      // IF
      if (w_taken)                   r_pc <= w_target;
      else if (!w_stall && !w_freeze) r_pc <= r_pc + AW'(1);
      if (w_taken || (!w_stall && w_freeze)) begin
        r_ifid_v <= 1'b0;
      end else if (!w_stall) begin
        r_ifid_v  <= 1'b1;
        r_ifid_ir <= Mem[r_pc][31:0];
        r_ifid_pc <= r_pc;
      end
      // Freeze persists once HLT has survived ID; a flushed HLT never sets it.
      if (w_id_hlt && !w_taken) r_fetch_frozen <= 1'b1;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
      // ID -> EX
      if (w_taken || w_stall) begin
        r_idex_v  <= 1'b0;
        r_idex_we <= 1'b0;
      end else begin
        r_idex_v   <= r_ifid_v;
        r_idex_we  <= w_we;
        r_idex_op  <= w_op;
        r_idex_rs  <= w_rs;
        r_idex_rt  <= w_rt;
        r_idex_dst <= w_dst;
        r_idex_a   <= w_id_a;
        r_idex_b   <= w_id_b;
        r_idex_imm <= w_imm;
        r_idex_pc  <= r_ifid_pc;
      end
      // EX -> MEM
      r_exmem_v   <= r_idex_v;
      r_exmem_we  <= r_idex_we;
      r_exmem_lw  <= r_idex_v && (r_idex_op == OP_LW);
      r_exmem_sw  <= r_idex_v && (r_idex_op == OP_SW);
      r_exmem_hlt <= r_idex_v && (r_idex_op == OP_HLT);
      r_exmem_dst <= r_idex_dst;
      r_exmem_res <= w_alu;
      r_exmem_sd  <= w_fb;
      // MEM -> WB
      r_memwb_v   <= r_exmem_v;
      r_memwb_we  <= r_exmem_we;
      r_memwb_hlt <= r_exmem_hlt;
      r_memwb_dst <= r_exmem_dst;
      r_memwb_res <= w_mem_res;
      // WB
      if (r_memwb_v && r_memwb_hlt) r_halted <= 1'b1;
    end
  end

  // Architectural storage: not reset; write enables are already cleared by reset.
  always_ff @(posedge clk1) begin
    if (r_exmem_sw) Mem[w_mem_addr] <= MEM_W'(r_exmem_sd);
    if (r_memwb_we) Reg[r_memwb_dst] <= r_memwb_res;
  end

  assign halted       = r_halted;
  assign retire_pulse = r_memwb_v;
  assign stall_count  = r_stall_cnt;
endmodule
